// File: rtl/alu_op_arbiter.sv
// Round-robin front end for one shared combinational 4-bit ALU: grants a requester,
// registers its operands, captures the ALU result and returns it tagged with the requester id.
module alu_op_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [4*NUM_REQ-1:0] req_a_i,
    input  logic [4*NUM_REQ-1:0] req_b_i,
    input  logic [4*NUM_REQ-1:0] req_op_i,
    output logic [3:0]           alu_a_o,
    output logic [3:0]           alu_b_o,
    output logic [3:0]           alu_op_o,
    input  logic [3:0]           alu_out_i,
    input  logic                 alu_z_i,
    input  logic                 alu_c_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [ID_W-1:0]      resp_id_o,
    output logic [3:0]           resp_data_o,
    output logic                 resp_z_o,
    output logic                 resp_c_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     ops_done_o
);

    localparam int unsigned D_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [D_W-1:0]   a_q, a_d, b_q, b_d, op_q, op_d;
    logic [D_W-1:0]   data_q, data_d;
    logic             z_q, z_d, c_q, c_d;
    logic             rv_q, rv_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_vld;
    logic [ID_W-1:0]  pick_idx;
    logic [D_W-1:0]   a_sel, b_sel, op_sel;
    int unsigned      cand;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_vld && (|(req_valid_i & (NUM_REQ'(1) << cand)))) begin
                pick_vld = 1'b1;
                pick_idx = ID_W'(cand);
            end
        end
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                a_sel  = req_a_i[D_W*i +: D_W];
                b_sel  = req_b_i[D_W*i +: D_W];
                op_sel = req_op_i[D_W*i +: D_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        data_d      = data_q;
        z_d         = z_q;
        c_d         = c_q;
        rv_d        = rv_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    req_ready_o = NUM_REQ'(1) << pick_idx;
                    a_d         = a_sel;
                    b_d         = b_sel;
                    op_d        = op_sel;
                    last_d      = pick_idx;
                    id_d        = pick_idx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Carry is only meaningful for the arithmetic opcodes 0100..0111
                data_d  = alu_out_i;
                z_d     = alu_z_i;
                c_d     = alu_c_i & (op_q[3:2] == 2'b01);
                rv_d    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    rv_d    = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            z_q     <= z_d;
            c_q     <= c_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_op_o     = op_q;
    assign resp_valid_o = rv_q;
    assign resp_id_o    = id_q;
    assign resp_data_o  = data_q;
    assign resp_z_o     = z_q;
    assign resp_c_o     = c_q;
    assign busy_o       = busy_q;
    assign ops_done_o   = cnt_q;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: a transaction-level model checked every cycle, plus directed
// scenarios with literal expectations (grant order, backpressure, reset mid-op, counter wrap).
module tb_alu_op_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a = '0, req_b = '0, req_op = '0;
    logic [3:0]           alu_a, alu_b, alu_op, alu_out;
    logic                 alu_z, alu_c;
    logic                 resp_valid;
    logic                 resp_ready = 1'b1;
    logic [ID_W-1:0]      resp_id;
    logic [3:0]           resp_data;
    logic                 resp_z, resp_c, busy;
    logic [CNT_W-1:0]     ops_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_op_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_out_i(alu_out), .alu_z_i(alu_z), .alu_c_i(alu_c),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id), .resp_data_o(resp_data),
        .resp_z_o(resp_z), .resp_c_o(resp_c),
        .busy_o(busy), .ops_done_o(ops_done)
    );

    // Shared ALU: logic ops deliberately report carry=1 so the response-side masking is visible
    function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic [4:0] s;
        case (op)
            4'b0100: s = {1'b0, a} + {1'b0, b};
            4'b0101: s = {1'b0, a} + {1'b0, b} + 5'd1;
            4'b0110: s = {1'b0, a} + {1'b0, ~b} + 5'd1;
            4'b0111: s = {1'b0, a} + {1'b0, ~b};
            4'b1000: s = {1'b1, a & b};
            4'b1001: s = {1'b1, a | b};
            4'b1010: s = {1'b1, a ^ b};
            4'b1011: s = {1'b1, ~a};
            default: s = {1'b1, a};
        endcase
        return {s[4], (s[3:0] == 4'd0), s[3:0]};
    endfunction

    assign {alu_c, alu_z, alu_out} = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            int idx;
            idx = (last + k) % int'(NUM_REQ);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Transaction model: one op in flight; result visible from the second cycle after grant
    bit         m_busy = 0, m_vis = 0;
    int         m_last = NUM_REQ - 1;
    int         m_id = 0, m_cnt = 0;
    logic [3:0] m_a = '0, m_b = '0, m_op = '0, m_data = '0;
    logic       m_z = 1'b0, m_c = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_vis = 0; m_last = NUM_REQ - 1; m_id = 0; m_cnt = 0;
            m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_z = 1'b0; m_c = 1'b0;
        end else if (!m_busy) begin
            int g;
            g = pick(req_valid, m_last);
            if (g >= 0) begin
                logic [5:0] r;
                m_busy = 1; m_vis = 0; m_last = g; m_id = g;
                m_a  = req_a[4*g +: 4];
                m_b  = req_b[4*g +: 4];
                m_op = req_op[4*g +: 4];
                r = alu_fn(m_a, m_b, m_op);
                m_data = r[3:0];
                m_z    = r[4];
                m_c    = (int'(m_op) >= 4 && int'(m_op) <= 7) ? r[5] : 1'b0;
            end
        end else if (!m_vis) begin
            m_vis = 1;
        end else if (resp_ready) begin
            m_busy = 0; m_vis = 0; m_cnt = (m_cnt + 1) % 256;
        end
    end

    int cyc = 0;
    int gq_id[$];
    int gq_cyc[$];

    always @(negedge clk) begin
        int g, exp_ready;
        #1;
        cyc++;
        g = m_busy ? -1 : pick(req_valid, m_last);
        exp_ready = (g < 0) ? 0 : (1 << g);
        chk("req_ready", int'(req_ready), exp_ready);
        chk("busy", int'(busy), int'(m_busy));
        chk("resp_valid", int'(resp_valid), int'(m_busy && m_vis));
        chk("alu_a", int'(alu_a), int'(m_a));
        chk("alu_b", int'(alu_b), int'(m_b));
        chk("alu_op", int'(alu_op), int'(m_op));
        chk("ops_done", int'(ops_done), m_cnt);
        if (rst || (m_busy && m_vis)) begin
            chk("resp_id", int'(resp_id), m_id);
            chk("resp_data", int'(resp_data), int'(m_data));
            chk("resp_z", int'(resp_z), int'(m_z));
            chk("resp_c", int'(resp_c), int'(m_c));
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_ready[i]) begin
                gq_id.push_back(i);
                gq_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_op[4*i +: 4] = op;
    endtask

    // Raise valid, hold it until granted (bounded), drop it on the following cycle
    task automatic send(input int i, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int t = 0;
        @(negedge clk);
        set_req(i, a, b, op);
        req_valid[i] = 1'b1;
        #2;
        while (!req_ready[i] && t < 20) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("grant_wait", int'(req_ready[i]), 1);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    initial begin
        int exp_ord[4];
        int need;
        exp_ord = '{0, 1, 0, 1};

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_ops", int'(ops_done), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        @(negedge clk);
        rst = 1'b0;

        // Both requesters continuously valid: alternate, one grant every 3 clocks
        @(negedge clk);
        gq_id.delete();
        gq_cyc.delete();
        set_req(0, 4'd1, 4'd2, 4'b0100);
        set_req(1, 4'd9, 4'd4, 4'b0110);
        req_valid = 2'b11;
        repeat (12) @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("rr_grant_count", gq_id.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq_id.size()) chk("rr_order", gq_id[i], exp_ord[i]);
            if (i > 0 && i < gq_cyc.size()) chk("rr_spacing", gq_cyc[i] - gq_cyc[i-1], 3);
        end
        #2;
        chk("rr_ops_done", int'(ops_done), 4);

        // Single request: 3+5 add, result two clocks after grant
        @(negedge clk);
        set_req(0, 4'd3, 4'd5, 4'b0100);
        req_valid = 2'b01;
        #2;
        chk("t1_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #2;
        chk("t1_valid", int'(resp_valid), 1);
        chk("t1_data", int'(resp_data), 8);
        chk("t1_z", int'(resp_z), 0);
        chk("t1_c", int'(resp_c), 0);
        chk("t1_id", int'(resp_id), 0);

        // Backpressure on a 5-5 subtract, with requester 0 waiting during RESP
        @(negedge clk);
        resp_ready = 1'b0;
        send(1, 4'd5, 4'd5, 4'b0110);
        @(negedge clk);
        #2;
        chk("t4_data", int'(resp_data), 0);
        chk("t4_z", int'(resp_z), 1);
        chk("t4_c", int'(resp_c), 1);
        chk("t4_id", int'(resp_id), 1);
        chk("t3_ops_before", int'(ops_done), 5);
        set_req(0, 4'hF, 4'hF, 4'b1000);
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("t3_hold_valid", int'(resp_valid), 1);
            chk("t3_hold_data", int'(resp_data), 0);
            chk("t3_hold_id", int'(resp_id), 1);
            chk("t3_no_ready", int'(req_ready), 0);
            chk("t3_busy", int'(busy), 1);
            chk("t3_ops_stall", int'(ops_done), 5);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("t3_ops_after", int'(ops_done), 6);
        chk("t3_regrant", int'(req_ready), 1);
        chk("t3_valid_low", int'(resp_valid), 0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        #2;
        chk("t4b_data", int'(resp_data), 15);
        chk("t4b_z", int'(resp_z), 0);
        chk("t4b_c", int'(resp_c), 0);
        chk("t4b_id", int'(resp_id), 0);

        // Reset while the op is in ISSUE
        send(1, 4'd2, 4'd3, 4'b0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("t5_no_resp", int'(resp_valid), 0);
            chk("t5_idle", int'(busy), 0);
            chk("t5_ops", int'(ops_done), 0);
        end
        @(negedge clk);
        set_req(0, 4'd7, 4'd1, 4'b0111);
        set_req(1, 4'd4, 4'd4, 4'b1010);
        req_valid = 2'b11;
        #2;
        chk("t5_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);

        // Every opcode once, random operands, checked by the model
        for (int op = 0; op < 16; op++) begin
            send(op % 2, 4'($urandom), 4'($urandom), 4'(op));
        end
        repeat (2) @(negedge clk);

        // Counter wrap
        need = 255 - m_cnt;
        @(negedge clk);
        set_req(0, 4'd6, 4'd2, 4'b0101);
        req_valid[0] = 1'b1;
        repeat (3 * need) @(negedge clk);
        req_valid[0] = 1'b0;
        #2;
        chk("t6_ops_255", int'(ops_done), 255);
        send(0, 4'd1, 4'd1, 4'b0100);
        repeat (2) @(negedge clk);
        #2;
        chk("t6_ops_wrap", int'(ops_done), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
